// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter_ctrl block: command codes and FSM state encodings.
package counter_ctrl_pkg;

  // Host command codes carried on ipCmd.
  typedef enum logic [1:0] {
    CMD_STOP       = 2'd0,
    CMD_START_UP   = 2'd1,
    CMD_START_DOWN = 2'd2,
    CMD_LOAD       = 2'd3
  } cmd_e;

  // Run/stop FSM states, visible on opState.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command handshake and LED/status bus between a host (master) and counter_ctrl (slave).
interface counter_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       ipCmd;
  logic             ipCmdValid;
  logic             opCmdReady;
  logic [WIDTH-1:0] ipLoadValue;
  logic [WIDTH-1:0] opLED;
  logic             opTick;
  logic [1:0]       opState;

  modport master (
    output ipCmd, ipCmdValid, ipLoadValue,
    input  opCmdReady, opLED, opTick, opState
  );

  modport slave (
    input  ipCmd, ipCmdValid, ipLoadValue,
    output opCmdReady, opLED, opTick, opState
  );
endinterface

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler for counter_ctrl: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
// opStep is combinational and marks the edge on which the count should step.
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic ipClk,
  input  logic ipReset,
  input  logic ipClear,
  input  logic ipEnable,
  output logic opStep
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign opStep  = ipEnable && at_last;

  // Next prescaler value: clear wins, idle holds at zero, running wraps at LAST.
  always_comb begin
    cnt_d = '0;
    if (!ipClear && ipEnable && !at_last) begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge ipClk or negedge ipReset) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!ipReset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/counter_ctrl.sv
// Run/stop controller and step scheduler for the LED counter.
// Optional feature: define COUNTER_CTRL_PINGPONG_EN to reverse direction at the
// count limits instead of wrapping.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int WIDTH   = 8
) (
  input  logic          ipClk,
  input  logic          ipReset,
  counter_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             step;
  cmd_e             cmd;

  assign cmd    = cmd_e'(bus.ipCmd);
  assign accept = bus.ipCmdValid && ready_q;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .ipClk    (ipClk),
    .ipReset  (ipReset),
    .ipClear  (accept),
    .ipEnable (state_q != ST_IDLE),
    .opStep   (step)
  );

  // Next-state: an accepted command overrides any step on the same edge.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    ready_d = 1'b1;
    if (accept) begin
      ready_d = 1'b0;
      unique case (cmd)
        CMD_STOP:       state_d = ST_IDLE;
        CMD_START_UP:   state_d = ST_UP;
        CMD_START_DOWN: state_d = ST_DOWN;
        CMD_LOAD: begin
          count_d = bus.ipLoadValue;
          state_d = ST_IDLE;
        end
      endcase
    end else if (step) begin
      tick_d = 1'b1;
      if (state_q == ST_UP) begin
`ifdef COUNTER_CTRL_PINGPONG_EN
        if (count_q == CNT_MAX) begin
          count_d = CNT_MAX - WIDTH'(1);
          state_d = ST_DOWN;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
`else
        count_d = count_q + WIDTH'(1);
`endif
      end else begin
`ifdef COUNTER_CTRL_PINGPONG_EN
        if (count_q == '0) begin
          count_d = WIDTH'(1);
          state_d = ST_UP;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
`else
        count_d = count_q - WIDTH'(1);
`endif
      end
    end
  end

  // State, count, tick and ready registers.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
    end
  end

  assign bus.opCmdReady = ready_q;
  assign bus.opLED      = count_q;
  assign bus.opTick     = tick_q;
  assign bus.opState    = state_q;

  // Compile-time guard on the prescaler period.
  if (CLK_DIV < 2) begin : g_bad_div
    $error("counter_ctrl: CLK_DIV must be >= 2");
  end
endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl (CLK_DIV=4, WIDTH=8): directed vector
// table, hand-written corner sequences, then random commands against a model.
module tb_counter_ctrl;
  localparam int CLK_DIV = 4;
  localparam int WIDTH   = 8;
  localparam int MAXV    = (1 << WIDTH) - 1;

  logic ipClk;
  logic ipReset;

  counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_ctrl #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH)) dut (
    .ipClk   (ipClk),
    .ipReset (ipReset),
    .bus     (bus)
  );

  initial ipClk = 1'b0;
  always #5 ipClk = ~ipClk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle / 1 up / 2 down, cycles elapsed since the last
  // accepted command; a step lands every CLK_DIV cycles of running.
  int m_mode, m_cnt, m_el, m_ready, m_tick;

  typedef struct {
    int cmd;
    int valid;
    int load;
    int led;
    int state;
    int tick;
    int ready;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_el = 0; m_ready = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit acc, input int cmd, input int load);
    m_tick = 0;
    if (acc) begin
      m_ready = 0;
      m_el    = 0;
      case (cmd)
        0: m_mode = 0;
        1: m_mode = 1;
        2: m_mode = 2;
        default: begin m_cnt = load; m_mode = 0; end
      endcase
    end else begin
      m_ready = 1;
      if (m_mode != 0) begin
        m_el++;
        if (m_el % CLK_DIV == 0) begin
          m_tick = 1;
`ifdef COUNTER_CTRL_PINGPONG_EN
          if (m_mode == 1 && m_cnt == MAXV) begin m_cnt = MAXV - 1; m_mode = 2; end
          else if (m_mode == 2 && m_cnt == 0) begin m_cnt = 1; m_mode = 1; end
          else if (m_mode == 1) m_cnt = m_cnt + 1;
          else m_cnt = m_cnt - 1;
`else
          if (m_mode == 1) m_cnt = (m_cnt + 1) % (MAXV + 1);
          else             m_cnt = (m_cnt + MAXV) % (MAXV + 1);
`endif
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic drive(input int cmd, input bit valid, input int load);
    bit acc;
    bus.ipCmd       = 2'(cmd);
    bus.ipCmdValid  = valid;
    bus.ipLoadValue = WIDTH'(load);
    acc = valid && (m_ready != 0);
    @(posedge ipClk);
    #1;
    model_edge(acc, cmd, load);
  endtask

  task automatic check_all(input string tag, input int led, input int st,
                           input int tk, input int rdy);
    check({tag, "_led"},   int'(bus.opLED),      led);
    check({tag, "_state"}, int'(bus.opState),    st);
    check({tag, "_tick"},  int'(bus.opTick),     tk);
    check({tag, "_ready"}, int'(bus.opCmdReady), rdy);
  endtask

  task automatic add(input int c, input int v, input int l, input int led,
                     input int st, input int tk, input int rdy);
    vecs.push_back('{cmd:c, valid:v, load:l, led:led, state:st, tick:tk, ready:rdy});
  endtask

  initial begin
    ipReset         = 1'b0;
    bus.ipCmd       = 2'd0;
    bus.ipCmdValid  = 1'b0;
    bus.ipLoadValue = '0;
    model_reset();

    // Reset values while held.
    #3;
    check_all("reset", 0, 0, 0, 0);
    #9;
    ipReset = 1'b1;
    drive(0, 0, 0);
    check_all("release", 0, 0, 0, 1);

    // Directed table: START_UP timing, LOAD 0xFE wrap, ignored command while
    // ready is low, LOAD 0x00 then START_DOWN.
    add(1, 1, 0,    0, 1, 0, 0);
    add(0, 0, 0,    0, 1, 0, 1);
    add(0, 0, 0,    0, 1, 0, 1);
    add(0, 0, 0,    0, 1, 0, 1);
    add(0, 0, 0,    1, 1, 1, 1);
    add(0, 0, 0,    1, 1, 0, 1);
    add(0, 0, 0,    1, 1, 0, 1);
    add(0, 0, 0,    1, 1, 0, 1);
    add(0, 0, 0,    2, 1, 1, 1);
    add(3, 1, 8'hFE, 8'hFE, 0, 0, 0);
    add(1, 1, 0,    8'hFE, 0, 0, 1);
    add(1, 1, 0,    8'hFE, 1, 0, 0);
    add(0, 0, 0,    8'hFE, 1, 0, 1);
    add(0, 0, 0,    8'hFE, 1, 0, 1);
    add(0, 0, 0,    8'hFE, 1, 0, 1);
    add(0, 0, 0,    8'hFF, 1, 1, 1);
    add(0, 0, 0,    8'hFF, 1, 0, 1);
    add(0, 0, 0,    8'hFF, 1, 0, 1);
    add(0, 0, 0,    8'hFF, 1, 0, 1);
`ifdef COUNTER_CTRL_PINGPONG_EN
    add(0, 0, 0,    8'hFE, 2, 1, 1);
`else
    add(0, 0, 0,    8'h00, 1, 1, 1);
`endif
    add(3, 1, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 0,    8'h00, 0, 0, 1);
    add(2, 1, 0,    8'h00, 2, 0, 0);
    add(0, 0, 0,    8'h00, 2, 0, 1);
    add(0, 0, 0,    8'h00, 2, 0, 1);
    add(0, 0, 0,    8'h00, 2, 0, 1);
`ifdef COUNTER_CTRL_PINGPONG_EN
    add(0, 0, 0,    8'h01, 1, 1, 1);
`else
    add(0, 0, 0,    8'hFF, 2, 1, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cmd, vecs[i].valid[0], vecs[i].load);
      check_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].state,
                vecs[i].tick, vecs[i].ready);
    end

    // STOP accepted on the exact step edge: no change, no tick, held 20 cycles.
    drive(3, 1, 8'h10);
    drive(0, 0, 0);
    drive(1, 1, 0);
    for (int i = 0; i < CLK_DIV - 1; i++) drive(0, 0, 0);
    drive(0, 1, 0);
    check_all("stop_on_step", 8'h10, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0);
      check($sformatf("stop_hold%0d_led", i), int'(bus.opLED), 8'h10);
      check($sformatf("stop_hold%0d_tick", i), int'(bus.opTick), 0);
    end

    // START_DOWN held through the ready-low cycle is taken only once ready returns.
    drive(3, 1, 8'h20);
    drive(2, 1, 0);
    check_all("hold_ignored", 8'h20, 0, 0, 1);
    drive(2, 1, 0);
    check_all("hold_taken", 8'h20, 2, 0, 0);
    drive(0, 0, 0);
    check_all("hold_after", 8'h20, 2, 0, 1);

    // Asynchronous reset mid-run at count 5.
    drive(3, 1, 4);
    drive(0, 0, 0);
    drive(1, 1, 0);
    for (int i = 0; i < CLK_DIV; i++) drive(0, 0, 0);
    check_all("run_to5", 5, 1, 1, 1);
    #2;
    ipReset = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0);
    model_reset();
    @(posedge ipClk);
    #3;
    check_all("reset_held", 0, 0, 0, 0);
    ipReset = 1'b1;
    drive(0, 0, 0);
    check_all("rerelease", 0, 0, 0, 1);

    // Random commands against the model; loads biased towards the wrap points.
    for (int i = 0; i < 1500; i++) begin
      int c, l;
      bit v;
      c = $urandom_range(0, 3);
      v = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: l = 0;
        1: l = MAXV;
        default: l = $urandom_range(0, MAXV);
      endcase
      drive(c, v, l);
      check_all($sformatf("rnd%0d", i), m_cnt, m_mode, m_tick, m_ready);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
